// File: rtl/mycpu_seq_ctrl.sv
// mycpu_seq_ctrl: multi-cycle instruction sequencer for the myCPU core.
// Steps each instruction through IF -> ID -> EX -> [MEM] -> [WB], drives the
// instruction/data SRAM handshakes, the IR/PC load strobes and the register
// file write enable, and counts retired instructions.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   run        in   keep issuing instructions (sampled in IDLE and at retire)
//   inst_req   out  instruction fetch request (IF)
//   inst_ack   in   fetch complete, instruction valid
//   data_req   out  data memory request (MEM)
//   data_wr    out  1 = store, 0 = load; valid with data_req
//   data_ack   in   data access complete
//   dec_load   in   decoded load
//   dec_store  in   decoded store
//   dec_wen    in   decoded register-file write
//   dec_branch in   decoded PC redirect
//   ir_we      out  latch fetched instruction (IF & inst_ack)
//   pc_we      out  PC update at retire
//   pc_sel     out  0 = PC+4, 1 = jump target; valid with pc_we
//   rf_wen     out  register-file write enable (WB only)
//   wb_sel     out  1 = memory data, 0 = ALU result
//   state      out  current state encoding
//   instret    out  retired-instruction counter (wraps)
module mycpu_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        inst_req,
    input  logic        inst_ack,
    output logic        data_req,
    output logic        data_wr,
    input  logic        data_ack,
    input  logic        dec_load,
    input  logic        dec_store,
    input  logic        dec_wen,
    input  logic        dec_branch,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        rf_wen,
    output logic        wb_sel,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_br_q;
    logic [CNT_W-1:0]   r_instret;
    logic               w_retire;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        w_next   = r_state;
        inst_req = 1'b0;
        ir_we    = 1'b0;
        data_req = 1'b0;
        data_wr  = 1'b0;
        rf_wen   = 1'b0;
        wb_sel   = 1'b0;
        pc_sel   = 1'b0;
        pc_we    = 1'b0;
        w_retire = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) w_next = S_IF;
            end
            S_IF: begin
                inst_req = 1'b1;
                if (inst_ack) begin
                    ir_we  = 1'b1;
                    w_next = S_ID;
                end
            end
            S_ID: begin
                w_next = S_EX;
            end
            S_EX: begin
                if (dec_load || dec_store) begin
                    w_next = S_MEM;
                end else if (dec_wen) begin
                    w_next = S_WB;
                end else begin
                    // br_q is only being captured this edge, so use the decode directly
                    w_retire = 1'b1;
                    pc_sel   = dec_branch;
                end
            end
            S_MEM: begin
                data_req = 1'b1;
                data_wr  = dec_store;
                if (data_ack) begin
                    if (dec_load) begin
                        w_next = S_WB;
                    end else begin
                        w_retire = 1'b1;
                        pc_sel   = r_br_q;
                    end
                end
            end
            S_WB: begin
                rf_wen   = 1'b1;
                wb_sel   = dec_load;
                w_retire = 1'b1;
                pc_sel   = r_br_q;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        pc_we = w_retire;
        if (w_retire) begin
            w_next = run ? S_IF : S_IDLE;
        end
    end

    // Branch decision latch and retired-instruction counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_br_q    <= 1'b0;
            r_instret <= '0;
        end else begin
            if (r_state == S_EX) begin
                r_br_q <= dec_branch;
            end
            if (w_retire) begin
                r_instret <= CNT_W'(r_instret + CNT_W'(1));
            end
        end
    end

    assign state   = r_state;
    assign instret = r_instret;

endmodule

// File: tb/tb_mycpu_seq_ctrl.sv
// Directed bench for mycpu_seq_ctrl: steps instruction mixes cycle by cycle
// and compares state, strobes and the retire counter against hand values.
module tb_mycpu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        inst_req;
    logic        inst_ack;
    logic        data_req;
    logic        data_wr;
    logic        data_ack;
    logic        dec_load;
    logic        dec_store;
    logic        dec_wen;
    logic        dec_branch;
    logic        ir_we;
    logic        pc_we;
    logic        pc_sel;
    logic        rf_wen;
    logic        wb_sel;
    logic [2:0]  state;
    logic [31:0] instret;
    logic [7:0]  w_outs;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mycpu_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .inst_req   (inst_req),
        .inst_ack   (inst_ack),
        .data_req   (data_req),
        .data_wr    (data_wr),
        .data_ack   (data_ack),
        .dec_load   (dec_load),
        .dec_store  (dec_store),
        .dec_wen    (dec_wen),
        .dec_branch (dec_branch),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .rf_wen     (rf_wen),
        .wb_sel     (wb_sel),
        .state      (state),
        .instret    (instret)
    );

    // {inst_req, ir_we, data_req, data_wr, pc_we, pc_sel, rf_wen, wb_sel}
    assign w_outs = {inst_req, ir_we, data_req, data_wr, pc_we, pc_sel, rf_wen, wb_sel};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check state/strobes 1 time unit after the negedge, then advance one cycle
    task automatic step(input string tag, input logic [2:0] st, input logic [7:0] outs);
        #1;
        chk({tag, " state"}, 32'(state), 32'(st));
        chk({tag, " outs"},  32'(w_outs), 32'(outs));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; run = 1'b1; inst_ack = 1'b1; data_ack = 1'b1;
        dec_load = 1'b0; dec_store = 1'b0; dec_wen = 1'b0; dec_branch = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 chk("rst instret", instret, 32'd0);
        step("rst", 3'd0, 8'b0000_0000);

        // Release reset: first IF one edge later
        rst = 1'b1; inst_ack = 1'b0; data_ack = 1'b0;
        step("rel", 3'd0, 8'b0000_0000);

        // ALU with two fetch wait cycles
        dec_wen = 1'b1;
        step("alu if0", 3'd1, 8'b1000_0000);
        step("alu if1", 3'd1, 8'b1000_0000);
        inst_ack = 1'b1;
        step("alu if2", 3'd1, 8'b1100_0000);
        inst_ack = 1'b0;
        step("alu id", 3'd2, 8'b0000_0000);
        step("alu ex", 3'd3, 8'b0000_0000);
        step("alu wb", 3'd5, 8'b0000_1010);
        #1 chk("alu instret", instret, 32'd1);

        // Load, one data wait cycle
        dec_load = 1'b1; inst_ack = 1'b1;
        step("ld if", 3'd1, 8'b1100_0000);
        inst_ack = 1'b0;
        step("ld id", 3'd2, 8'b0000_0000);
        step("ld ex", 3'd3, 8'b0000_0000);
        step("ld mem0", 3'd4, 8'b0010_0000);
        data_ack = 1'b1;
        step("ld mem1", 3'd4, 8'b0010_0000);
        data_ack = 1'b0;
        step("ld wb", 3'd5, 8'b0000_1011);
        #1 chk("ld instret", instret, 32'd2);

        // Store, immediate acks; data_ack raised in EX must be ignored there
        dec_load = 1'b0; dec_store = 1'b1; dec_wen = 1'b0; inst_ack = 1'b1;
        step("st if", 3'd1, 8'b1100_0000);
        inst_ack = 1'b0;
        step("st id", 3'd2, 8'b0000_0000);
        data_ack = 1'b1;
        step("st ex", 3'd3, 8'b0000_0000);
        step("st mem", 3'd4, 8'b0011_1000);
        data_ack = 1'b0;
        #1 chk("st instret", instret, 32'd3);

        // jal: dec_branch dropped during WB, pc_sel must come from br_q
        dec_store = 1'b0; dec_branch = 1'b1; dec_wen = 1'b1; inst_ack = 1'b1;
        step("jal if", 3'd1, 8'b1100_0000);
        inst_ack = 1'b0;
        step("jal id", 3'd2, 8'b0000_0000);
        step("jal ex", 3'd3, 8'b0000_0000);
        dec_branch = 1'b0;
        step("jal wb", 3'd5, 8'b0000_1110);
        #1 chk("jal instret", instret, 32'd4);

        // beq taken, retires in EX
        dec_wen = 1'b0; dec_branch = 1'b1; inst_ack = 1'b1;
        step("beq if", 3'd1, 8'b1100_0000);
        inst_ack = 1'b0;
        step("beq id", 3'd2, 8'b0000_0000);
        step("beq ex", 3'd3, 8'b0000_1100);
        #1 chk("beq instret", instret, 32'd5);

        // Counter wrap on a non-writing, non-branch instruction
        dec_branch = 1'b0; inst_ack = 1'b1;
        force dut.r_instret = 32'hFFFF_FFFF;
        #1 release dut.r_instret;
        chk("wrap preload", instret, 32'hFFFF_FFFF);
        step("nop if", 3'd1, 8'b1100_0000);
        inst_ack = 1'b0;
        step("nop id", 3'd2, 8'b0000_0000);
        step("nop ex", 3'd3, 8'b0000_1000);
        #1 chk("wrap instret", instret, 32'd0);

        // Load with run dropped during MEM: completes, then parks in IDLE
        dec_load = 1'b1; dec_wen = 1'b1; inst_ack = 1'b1;
        step("ldr if", 3'd1, 8'b1100_0000);
        inst_ack = 1'b0;
        step("ldr id", 3'd2, 8'b0000_0000);
        step("ldr ex", 3'd3, 8'b0000_0000);
        run = 1'b0;
        step("ldr mem0", 3'd4, 8'b0010_0000);
        data_ack = 1'b1;
        step("ldr mem1", 3'd4, 8'b0010_0000);
        data_ack = 1'b0;
        step("ldr wb", 3'd5, 8'b0000_1011);
        step("park0", 3'd0, 8'b0000_0000);
        step("park1", 3'd0, 8'b0000_0000);
        #1 chk("park instret", instret, 32'd1);

        // Store interrupted by reset in MEM
        run = 1'b1; dec_load = 1'b0; dec_wen = 1'b0; dec_store = 1'b1;
        step("idle run", 3'd0, 8'b0000_0000);
        inst_ack = 1'b1;
        step("rs if", 3'd1, 8'b1100_0000);
        inst_ack = 1'b0;
        step("rs id", 3'd2, 8'b0000_0000);
        step("rs ex", 3'd3, 8'b0000_0000);
        #1 chk("rs mem req", 32'(w_outs), 32'(8'b0011_0000));
        rst = 1'b0; data_ack = 1'b1;
        #1 chk("rs async state", 32'(state), 32'd0);
        chk("rs async outs", 32'(w_outs), 32'd0);
        chk("rs async instret", instret, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step("rs rel", 3'd0, 8'b0000_0000);
        step("rs if0", 3'd1, 8'b1000_0000);
        step("rs if1", 3'd1, 8'b1000_0000);
        data_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
